// File: rtl/dmem_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_ctrl
//   Word-organised data memory for the RV32I load/store unit.
//   Accepts one load or store per cycle over a valid/ready handshake, places
//   store bytes in the correct lanes, returns sign/zero-extended load data
//   after RD_LAT cycles, and flags misaligned or illegal-funct3 requests.
//   After reset an optional clear sequence zeroes every word before the first
//   request is accepted.
//
// Parameters
//   DMEM_ADDR    byte-address width; the word index is addr[DMEM_ADDR-1:2]
//   DEPTH_WORDS  number of 32-bit words in the array
//   RD_LAT       response latency in cycles, legal range 1..4
//   CLEAR_ON_RST 1 = zero the array after reset before accepting requests
//
// Ports
//   i_clk          clock, all state on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    request present
//   o_req_ready    controller can accept a request this cycle
//   i_req_we       1 = store, 0 = load
//   i_req_addr     byte address
//   i_req_funct3   RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   i_req_wdata    store data, right-aligned
//   o_rsp_valid    response valid, one cycle per accepted request
//   o_rsp_rdata    extended load data; 0 for stores and errors
//   o_rsp_err      misaligned access or illegal funct3
//   o_init_done    clear sequence finished
// ----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int DMEM_ADDR    = 13,
    parameter int DEPTH_WORDS  = 2**(DMEM_ADDR-2),
    parameter int RD_LAT       = 1,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [DMEM_ADDR-1:0] i_req_addr,
    input  logic [2:0]           i_req_funct3,
    input  logic [31:0]          i_req_wdata,
    output logic                 o_rsp_valid,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic                 o_init_done
);

    localparam int WIDX = DMEM_ADDR - 2;
    localparam logic [WIDX-1:0] CLR_LAST = WIDX'(DEPTH_WORDS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // ------------------------------------------------------------------------
    // Clear / run FSM
    // ------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [WIDX-1:0] clr_cnt_q, clr_cnt_d;
    logic            clr_we;
    logic            req_ready;
    logic            init_done;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge, independent of the
    // order in which always blocks are evaluated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (!CLEAR_ON_RST) begin
                    state_d = ST_RUN;
                end else if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + WIDX'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        init_done = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            ST_INIT: clr_we = CLEAR_ON_RST;
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
        endcase
    end

    assign o_req_ready = req_ready;
    assign o_init_done = init_done;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic            accept;
    logic            req_legal;
    logic            st_en;
    logic            rd_en;
    logic [WIDX-1:0] req_idx;
    logic [1:0]      req_lane;
    logic [3:0]      st_be;
    logic [31:0]     st_data;

    assign accept   = i_req_valid & req_ready;
    assign req_idx  = i_req_addr[DMEM_ADDR-1:2];
    assign req_lane = i_req_addr[1:0];

    // funct3[1:0] encodes the access size (00 byte, 01 half, 10 word);
    // funct3[2] marks the unsigned load variants, which stores do not have.
    function automatic logic is_legal(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] lane);
        logic code_ok;
        logic align_ok;
        if (we) code_ok = !f3[2] && (f3[1:0] != 2'b11);
        else    code_ok = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
        case (f3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = !lane[0];
            2'b10:   align_ok = (lane == 2'b00);
            default: align_ok = 1'b0;
        endcase
        return code_ok && align_ok;
    endfunction

    assign req_legal = is_legal(i_req_we, i_req_funct3, req_lane);
    assign st_en     = accept & i_req_we & req_legal;
    assign rd_en     = accept & ~i_req_we & req_legal;

    // Replicate the right-aligned store data across the word so that the
    // byte enables alone choose which lanes land in the array.
    always_comb begin
        st_be   = 4'b1111;
        st_data = i_req_wdata;
        case (i_req_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << req_lane;
                st_data = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = req_lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{i_req_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = i_req_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage array: one write port shared by the clear sequence and stores.
    // The clear only runs in INIT, where no request can be accepted.
    // ------------------------------------------------------------------------
    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     rd_word_q;
    logic            mem_we;
    logic [WIDX-1:0] mem_idx;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;

    assign mem_we    = clr_we | st_en;
    assign mem_idx   = clr_we ? clr_cnt_q : req_idx;
    assign mem_be    = clr_we ? 4'b1111 : st_be;
    assign mem_wdata = clr_we ? 32'h0 : st_data;

    // NOTE: the array and its read register have no reset so the array maps
    // onto RAM; zeroing is done by the clear sequence, and nothing downstream
    // consumes rd_word_q unless a valid load was accepted.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (rd_en) rd_word_q <= mem_q[req_idx];
    end

    // ------------------------------------------------------------------------
    // First response stage: request attributes aligned with the read word
    // ------------------------------------------------------------------------
    logic        s0_valid_q;
    logic        s0_err_q;
    logic        s0_load_q;
    logic [2:0]  s0_f3_q;
    logic [1:0]  s0_lane_q;
    logic [31:0] s0_rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
            s0_load_q  <= 1'b0;
            s0_f3_q    <= 3'b000;
            s0_lane_q  <= 2'b00;
        end else begin
            s0_valid_q <= accept;
            s0_err_q   <= accept & ~req_legal;
            s0_load_q  <= rd_en;
            if (accept) begin
                s0_f3_q   <= i_req_funct3;
                s0_lane_q <= req_lane;
            end
        end
    end

    always_comb begin
        byte_sel = rd_word_q[7:0];
        case (s0_lane_q)
            2'b00: byte_sel = rd_word_q[7:0];
            2'b01: byte_sel = rd_word_q[15:8];
            2'b10: byte_sel = rd_word_q[23:16];
            2'b11: byte_sel = rd_word_q[31:24];
        endcase
        half_sel = s0_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

        // Stores and errors never load s0_load_q, so they report zero data.
        s0_rdata = 32'h0;
        if (s0_load_q) begin
            case (s0_f3_q)
                3'b000:  s0_rdata = {{24{byte_sel[7]}}, byte_sel};
                3'b001:  s0_rdata = {{16{half_sel[15]}}, half_sel};
                3'b010:  s0_rdata = rd_word_q;
                3'b100:  s0_rdata = {24'h0, byte_sel};
                3'b101:  s0_rdata = {16'h0, half_sel};
                default: s0_rdata = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Remaining RD_LAT-1 delay stages, all cleared by reset so in-flight
    // responses are dropped rather than emitted after reset release.
    // ------------------------------------------------------------------------
    if (RD_LAT <= 1) begin : g_lat1
        assign o_rsp_valid = s0_valid_q;
        assign o_rsp_err   = s0_err_q;
        assign o_rsp_rdata = s0_rdata;
    end else begin : g_latn
        logic        dly_valid_q [RD_LAT-1];
        logic        dly_err_q   [RD_LAT-1];
        logic [31:0] dly_rdata_q [RD_LAT-1];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < RD_LAT-1; i++) begin
                    dly_valid_q[i] <= 1'b0;
                    dly_err_q[i]   <= 1'b0;
                    dly_rdata_q[i] <= 32'h0;
                end
            end else begin
                dly_valid_q[0] <= s0_valid_q;
                dly_err_q[0]   <= s0_err_q;
                dly_rdata_q[0] <= s0_rdata;
                for (int i = 1; i < RD_LAT-1; i++) begin
                    dly_valid_q[i] <= dly_valid_q[i-1];
                    dly_err_q[i]   <= dly_err_q[i-1];
                    dly_rdata_q[i] <= dly_rdata_q[i-1];
                end
            end
        end

        assign o_rsp_valid = dly_valid_q[RD_LAT-2];
        assign o_rsp_err   = dly_err_q[RD_LAT-2];
        assign o_rsp_rdata = dly_rdata_q[RD_LAT-2];
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_ctrl
//   Self-checking bench for dmem_ctrl with a 64-byte array (DMEM_ADDR=6),
//   RD_LAT=3 and the reset-time clear enabled. A byte-array reference model
//   predicts every response; a monitor matches responses in order and checks
//   the cycle on which each one appears.
// ----------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam int AW    = 6;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int NBYTE = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_f3;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          init_done;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DMEM_ADDR   (AW),
        .DEPTH_WORDS (DEPTH),
        .RD_LAT      (LAT),
        .CLEAR_ON_RST(1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_funct3(req_f3),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_init_done (init_done)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [5:0]  addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        string       name;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model_mem [NBYTE];
    int         n_vec = 0;
    int         n_mis = 0;
    int         cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Reference model: memory as a flat byte array, accesses as byte runs.
    task automatic model_op(input logic we, input logic [5:0] addr, input logic [2:0] f3,
                            input logic [31:0] wdata,
                            output logic err, output logic [31:0] rdata);
        int          sz;
        int          a;
        logic        legal;
        logic [31:0] v;
        a  = int'(addr);
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (f3[1:0] == 2'b11) legal = 1'b0;
        else if (we)          legal = (f3[2] == 1'b0);
        else                  legal = !(f3 == 3'b110);
        if (legal && (a % sz) != 0) legal = 1'b0;
        err   = !legal;
        rdata = 32'h0;
        if (legal && we) begin
            for (int i = 0; i < sz; i++) model_mem[a+i] = wdata[8*i +: 8];
        end else if (legal) begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(model_mem[a+i]) << (8*i));
            if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
            rdata = v;
        end
    endtask

    // Called at a falling edge; the request is accepted on the next rising edge.
    task automatic send(input string name, input logic we, input logic [5:0] addr,
                        input logic [2:0] f3, input logic [31:0] wdata,
                        input logic use_tbl, input logic t_err, input logic [31:0] t_rdata);
        exp_t        e;
        logic        m_err;
        logic [31:0] m_rdata;
        check({name, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_f3    = f3;
        req_wdata = wdata;
        model_op(we, addr, f3, wdata, m_err, m_rdata);
        e.name  = name;
        e.cyc   = cyc + LAT;
        e.err   = use_tbl ? t_err : m_err;
        e.rdata = use_tbl ? t_rdata : m_rdata;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            check({name, " responses outstanding"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Called at the falling edge where reset is released: ready must stay low
    // for exactly DEPTH cycles while the array is cleared.
    task automatic check_init(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s ready c%0d", name, i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        check({name, " ready after clear"}, 32'(req_ready), 32'd1);
        check({name, " init_done after clear"}, 32'(init_done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, " rsp_err"}, 32'(rsp_err), 32'd0);
        check({name, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({name, " req_ready"}, 32'(req_ready), 32'd0);
        check({name, " init_done"}, 32'(init_done), 32'd0);
    endtask

    // In-order response monitor with exact cycle check.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, " cycle"}, 32'(cyc), 32'(mon_e.cyc));
                check({mon_e.name, " err"}, 32'(rsp_err), 32'(mon_e.err));
                check({mon_e.name, " rdata"}, rsp_rdata, mon_e.rdata);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, " rsp_valid missing"}, 32'(rsp_valid), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[18];

    initial begin
        logic [5:0]  a;
        logic [2:0]  f3;
        logic        we;
        logic [2:0]  ld_codes [5];

        ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
        ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;

        // name, we, addr, f3, wdata, exp_err, exp_rdata
        tbl[0]  = '{"lw_cleared_3c", 1'b0, 6'h3C, 3'b010, 32'h0,         1'b0, 32'h0000_0000};
        tbl[1]  = '{"sw_10",         1'b1, 6'h10, 3'b010, 32'h1234_5678, 1'b0, 32'h0000_0000};
        tbl[2]  = '{"sb_11",         1'b1, 6'h11, 3'b000, 32'hFFFF_FFAA, 1'b0, 32'h0000_0000};
        tbl[3]  = '{"lw_10_raw",     1'b0, 6'h10, 3'b010, 32'h0,         1'b0, 32'h1234_AA78};
        tbl[4]  = '{"sh_22",         1'b1, 6'h22, 3'b001, 32'h5555_8001, 1'b0, 32'h0000_0000};
        tbl[5]  = '{"lh_22",         1'b0, 6'h22, 3'b001, 32'h0,         1'b0, 32'hFFFF_8001};
        tbl[6]  = '{"lhu_22",        1'b0, 6'h22, 3'b101, 32'h0,         1'b0, 32'h0000_8001};
        tbl[7]  = '{"lb_23",         1'b0, 6'h23, 3'b000, 32'h0,         1'b0, 32'hFFFF_FF80};
        tbl[8]  = '{"lbu_23",        1'b0, 6'h23, 3'b100, 32'h0,         1'b0, 32'h0000_0080};
        tbl[9]  = '{"sw_04",         1'b1, 6'h04, 3'b010, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
        tbl[10] = '{"lw_13_misal",   1'b0, 6'h13, 3'b010, 32'h0,         1'b1, 32'h0000_0000};
        tbl[11] = '{"sh_05_misal",   1'b1, 6'h05, 3'b001, 32'h0000_BEEF, 1'b1, 32'h0000_0000};
        tbl[12] = '{"ld_f3_011",     1'b0, 6'h00, 3'b011, 32'h0,         1'b1, 32'h0000_0000};
        tbl[13] = '{"st_f3_100",     1'b1, 6'h04, 3'b100, 32'h1111_1111, 1'b1, 32'h0000_0000};
        tbl[14] = '{"lw_04_intact",  1'b0, 6'h04, 3'b010, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[15] = '{"lb_11",         1'b0, 6'h11, 3'b000, 32'h0,         1'b0, 32'hFFFF_FFAA};
        tbl[16] = '{"lw_20_lanes",   1'b0, 6'h20, 3'b010, 32'h0,         1'b0, 32'h8001_0000};
        tbl[17] = '{"lh_20_zero",    1'b0, 6'h20, 3'b001, 32'h0,         1'b0, 32'h0000_0000};

        // Reset state and initial clear.
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_f3    = 3'b000;
        req_wdata = 32'h0;
        for (int i = 0; i < NBYTE; i++) model_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        check_init("init");

        // Directed vectors, issued back to back.
        for (int i = 0; i < 18; i++) begin
            send(tbl[i].name, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wdata,
                 1'b1, tbl[i].exp_err, tbl[i].exp_rdata);
        end
        drain("table");

        // Five back-to-back loads: five consecutive responses in order.
        send("b2b_lw_10",  1'b0, 6'h10, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0);
        send("b2b_lw_04",  1'b0, 6'h04, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0);
        send("b2b_lh_22",  1'b0, 6'h22, 3'b001, 32'h0, 1'b0, 1'b0, 32'h0);
        send("b2b_lbu_11", 1'b0, 6'h11, 3'b100, 32'h0, 1'b0, 1'b0, 32'h0);
        send("b2b_lw_20",  1'b0, 6'h20, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0);
        drain("b2b");

        // Randomised traffic with idle gaps.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
            end else begin
                we = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
                else if (we)                   f3 = 3'($urandom_range(0, 2));
                else                           f3 = ld_codes[$urandom_range(0, 4)];
                a = 6'($urandom_range(0, NBYTE-1));
                if ($urandom_range(0, 4) != 0) begin
                    if (f3[1:0] == 2'b10)      a = {a[5:2], 2'b00};
                    else if (f3[1:0] == 2'b01) a = {a[5:1], 1'b0};
                end
                send($sformatf("rnd%0d", n), we, a, f3, $urandom(), 1'b0, 1'b0, 32'h0);
            end
        end
        drain("random");

        // Reset with two responses in flight: both must be dropped, and the
        // clear must run again from word 0.
        send("pre_sw_3c", 1'b1, 6'h3C, 3'b010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        drain("pre_sw");
        send("flight_a", 1'b0, 6'h3C, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0);
        send("flight_b", 1'b0, 6'h10, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("mid_flight_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NBYTE; i++) model_mem[i] = 8'h00;
        repeat (5) @(negedge clk);
        check("mid_init rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_init("reinit");

        // Every word must read back as zero after the restarted clear.
        for (int w = 0; w < DEPTH; w++) begin
            send($sformatf("post_clear_w%0d", w), 1'b0, 6'(4*w), 3'b010, 32'h0,
                 1'b0, 1'b0, 32'h0);
        end
        drain("post_clear");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised, word-organised data memory for the RV32I load/store unit. Requests use a valid/ready handshake. Stores write correctly lane-placed bytes. Loads return sign- or zero-extended data after a configurable read latency. Misaligned and illegal accesses return an error response. A reset-time clear FSM zeroes the array before the first request is accepted.

Parameters:
DMEM_ADDR, 13, byte-address width; word index is addr[DMEM_ADDR-1:2]
DEPTH_WORDS, 2**(DMEM_ADDR-2), number of 32-bit words in the array
RD_LAT, 1, response latency in cycles; legal range 1..4
CLEAR_ON_RST, 1, 1 = zero the array after reset before accepting requests

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request present
o_req_ready  out  1  controller can accept a request this cycle
i_req_we  in  1  1 = store, 0 = load
i_req_addr  in  DMEM_ADDR  byte address
i_req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
i_req_wdata  in  32  store data, right-aligned
o_rsp_valid  out  1  response valid for exactly one cycle
o_rsp_rdata  out  32  extended load data; 0 for stores and errors
o_rsp_err  out  1  misaligned or illegal funct3
o_init_done  out  1  clear sequence finished

Behaviour:
- Reset (async assert):
  - o_rsp_valid, o_rsp_err, o_rsp_rdata = 0; o_req_ready = 0; o_init_done = 0.
  - All response-pipeline stages are invalidated; in-flight responses are dropped, never emitted.
- FSM states: INIT, RUN.
  - CLEAR_ON_RST=1: INIT is entered on reset release. The clear counter writes 0 to words 0..DEPTH_WORDS-1, one per cycle, so INIT lasts DEPTH_WORDS cycles. The FSM then moves to RUN.
  - CLEAR_ON_RST=0: the FSM goes straight to RUN; array contents are undefined.
  - Reset asserted mid-INIT restarts the clear from word 0.
- In RUN: o_req_ready = 1 and o_init_done = 1. In INIT both are 0; requests are ignored.
- Accept = i_req_valid & o_req_ready. At most one request per cycle; no backpressure on the response side.
- Legality check:
  - Load funct3 must be one of 000, 001, 010, 100, 101.
  - Store funct3 must be one of 000, 001, 010.
  - Half-word accesses require addr[0]=0; word accesses require addr[1:0]=00.
  - Any violation: no array write, o_rsp_err = 1, o_rsp_rdata = 0.
- Store (legal), write at the accept edge:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are untouched.
- Load (legal):
  - Synchronous word read at the accept edge.
  - The selected lane(s) are extracted by addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency: a request accepted at edge k produces o_rsp_valid high during the cycle after edge k+RD_LAT-1. Stores also produce a response (rdata 0) so responses stay in request order.
- Back-to-back requests produce back-to-back responses, one per cycle, in order.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated bytes.
- Address wrap: the word index uses only addr[DMEM_ADDR-1:2]; no out-of-range condition exists.

Test Plan:
1. Reset, CLEAR_ON_RST=1, DMEM_ADDR=6 -> o_req_ready = 0 for 16 cycles, then 1; LW at 0x3C returns 0x00000000.
2. SW 0x12345678 @0x10; SB 0xAA @0x11; LW @0x10 on the next cycle -> rdata 0x1234AA78, err=0.
3. SH 0x8001 @0x22; LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001; LB @0x23 -> 0xFFFFFF80.
4. LW @0x13, SH @0x05, funct3=011 load @0x00 -> each gives err=1, rdata 0; memory at 0x04 unchanged.
5. RD_LAT=3, five back-to-back loads -> five consecutive rsp_valid cycles, first 3 cycles after the first accept, data in request order.
6. Assert reset with 2 responses in flight -> no rsp_valid after reset release; INIT restarts from word 0.
